// File: rtl/memoria_dados.sv
// Data-memory responder: 2^ADDR_BITS x 16 RAM cleared after reset, optional LED register.
// Define MEM_IO_EN to map the LED register at IO_LED.
module memoria_dados #(
    parameter int unsigned ADDR_BITS = 7,
    parameter logic [15:0] IO_LED    = 16'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] daddr,
    input  logic [15:0] dout,
    input  logic        w,
    output logic [15:0] din,
    output logic        busy,
    output logic [15:0] leds
);

`ifdef MEM_IO_EN
    localparam bit IoEn = 1'b1;
`else
    localparam bit IoEn = 1'b0;
`endif

    localparam int unsigned Words = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LastPtr = {ADDR_BITS{1'b1}};

    typedef enum logic {StLimpa, StAtivo} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [15:0]            din_q, din_d;
    logic [15:0]            leds_q, leds_d;

    logic [15:0]            mem [Words];
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [15:0]            mem_wdata;

    logic                   ram_hit;
    logic                   led_hit;
    logic [ADDR_BITS-1:0]   ram_addr;

    // Upper address bits fully decoded so nothing aliases into the RAM.
    assign ram_hit  = (daddr >> ADDR_BITS) == 16'h0000;
    assign led_hit  = IoEn && (daddr == IO_LED);
    assign ram_addr = daddr[ADDR_BITS-1:0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        din_d     = din_q;
        leds_d    = leds_q;
        mem_we    = 1'b0;
        mem_waddr = ram_addr;
        mem_wdata = dout;
        unique case (state_q)
            StLimpa: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = 16'h0000;
                ptr_d     = ptr_q + 1'b1;
                din_d     = 16'h0000;
                if (ptr_q == LastPtr) begin
                    state_d = StAtivo;
                end
            end
            StAtivo: begin
                // Read uses the pre-edge array contents, giving read-before-write.
                if (ram_hit) begin
                    din_d = mem[ram_addr];
                end else if (led_hit) begin
                    din_d = leds_q;
                end else begin
                    din_d = 16'h0000;
                end
                if (w) begin
                    if (ram_hit) begin
                        mem_we = 1'b1;
                    end else if (led_hit) begin
                        leds_d = dout;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StLimpa;
            ptr_q   <= '0;
            din_q   <= 16'h0000;
            leds_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            din_q   <= din_d;
            leds_q  <= leds_d;
        end
    end

    // No reset on the array: the clear sequence zeroes it instead.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign din  = din_q;
    assign busy = (state_q == StLimpa);
    assign leds = IoEn ? leds_q : 16'h0000;

endmodule

// File: tb/tb_memoria_dados.sv
// Self-checking bench for memoria_dados: directed cases plus random traffic vs a simple model.
module tb_memoria_dados;

`ifdef MEM_IO_EN
    localparam bit IoEn = 1'b1;
`else
    localparam bit IoEn = 1'b0;
`endif

    localparam int Words = 128;

    logic        clock;
    logic        reset;
    logic [15:0] daddr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] din;
    logic        busy;
    logic [15:0] leds;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [Words];
    logic [15:0] ref_leds;

    memoria_dados #(
        .ADDR_BITS (7),
        .IO_LED    (16'h1000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .daddr (daddr),
        .dout  (dout),
        .w     (w),
        .din   (din),
        .busy  (busy),
        .leds  (leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_reset();
        for (int i = 0; i < Words; i++) ref_mem[i] = 16'h0000;
        ref_leds = 16'h0000;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (int'(a) < Words) return ref_mem[int'(a)];
        if (IoEn && a == 16'h1000) return ref_leds;
        return 16'h0000;
    endfunction

    function automatic void ref_write(input logic [15:0] a, input logic [15:0] d);
        if (int'(a) < Words) ref_mem[int'(a)] = d;
        else if (IoEn && a == 16'h1000) ref_leds = d;
    endfunction

    // One service cycle: drive at negedge, check registered outputs just after the edge.
    task automatic cycle(input string tag, input logic [15:0] a, input logic [15:0] d,
                         input logic we);
        logic [15:0] exp_din;
        @(negedge clock);
        daddr = a;
        dout  = d;
        w     = we;
        exp_din = ref_read(a);
        if (we) ref_write(a, d);
        @(posedge clock);
        #1;
        check({tag, "_din"}, {16'h0, din}, {16'h0, exp_din});
        check({tag, "_leds"}, {16'h0, leds}, {16'h0, ref_leds});
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
    endtask

    // Count edges from reset release until busy drops; din must stay 0 meanwhile.
    task automatic wait_clear(input string tag);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
            check({tag, "_clear_din"}, {16'h0, din}, 32'd0);
        end while (busy && n < 300);
        check({tag, "_clear_len"}, n, 32'd128);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int r;

        reset = 1'b0;
        daddr = 16'h0005;
        dout  = 16'hFFFF;
        w     = 1'b1;
        ref_reset();
        #1;
        check("rst_busy", {31'h0, busy}, 32'd1);
        check("rst_din", {16'h0, din}, 32'd0);
        check("rst_leds", {16'h0, leds}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_clear("init");

        cycle("rd5", 16'h0005, 16'h0000, 1'b0);
        cycle("wr3", 16'h0003, 16'h1234, 1'b1);
        cycle("rd3", 16'h0003, 16'h0000, 1'b0);
        cycle("rbw3", 16'h0003, 16'hBEEF, 1'b1);
        cycle("rd3b", 16'h0003, 16'h0000, 1'b0);
        cycle("wrled", 16'h1000, 16'h00A5, 1'b1);
        cycle("rdled", 16'h1000, 16'h0000, 1'b0);
        cycle("wrunm", 16'h0080, 16'hFFFF, 1'b1);
        cycle("rdunm", 16'h0080, 16'h0000, 1'b0);
        cycle("rd0", 16'h0000, 16'h0000, 1'b0);
        cycle("wr127", 16'h007F, 16'h7F7F, 1'b1);
        cycle("rd127", 16'h007F, 16'h0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99);
            if (r < 55) a = 16'($urandom_range(127));
            else if (r < 70) a = 16'h1000;
            else if (r < 80) a = 16'($urandom_range(2)) + 16'h0FFF;
            else if (r < 85) a = 16'h0080;
            else a = 16'($urandom);
            d = 16'($urandom);
            cycle("rand", a, d, 1'($urandom_range(1)));
        end

        cycle("wr3c", 16'h0003, 16'h1234, 1'b1);
        cycle("wrledc", 16'h1000, 16'h5A5A, 1'b1);
        cycle("rd3c", 16'h0003, 16'h0000, 1'b0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        daddr = 16'h0003;
        dout  = 16'hFFFF;
        w     = 1'b1;
        ref_reset();
        #1;
        check("midrst_busy", {31'h0, busy}, 32'd1);
        check("midrst_din", {16'h0, din}, 32'd0);
        check("midrst_leds", {16'h0, leds}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_clear("again");
        cycle("rd3d", 16'h0003, 16'h0000, 1'b0);
        cycle("rdledd", 16'h1000, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memoria_dados.md
# memoria_dados

Data-memory responder for the 16-bit processor: the far end of the processor's memory port. It consumes the processor's address, write-data and write-enable outputs and returns read data on the processor's `din` input. The block holds a 2^ADDR_BITS-word RAM, clears it after reset under a small state machine, and optionally maps a LED output register into the address space.

## Interface
Parameters:
- `ADDR_BITS`, default 7: RAM is 2^ADDR_BITS 16-bit words at addresses 0 .. 2^ADDR_BITS-1.
- `IO_LED`, default 16'h1000: address of the LED register; only used with `MEM_IO_EN`.

Ports:
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `daddr`, input, 16: word address from the processor.
- `dout`, input, 16: write data from the processor.
- `w`, input, 1: write enable; sampled every cycle.
- `din`, output, 16: registered read data to the processor.
- `busy`, output, 1: high while the clear sequence runs; the processor's run is gated by `~busy`.
- `leds`, output, 16: memory-mapped LED register.

## Operation
- Reset values while `reset`=0: state LIMPA, clear pointer 0, `busy`=1, `din`=16'h0000, `leds`=16'h0000.
- States:
  - LIMPA: each cycle writes 16'h0000 to RAM[ptr], then ptr+1. `w` is ignored, `din` is held at 0, and `busy`=1. After the cycle that writes ptr = 2^ADDR_BITS-1, the next state is ATIVO.
  - ATIVO: normal service with `busy`=0. It stays in ATIVO until reset.
- Address decode:
  - RAM hit: `daddr[15:ADDR_BITS]`=0.
  - LED hit: `daddr`=IO_LED.
  - Anything else is unmapped. There is no aliasing: the upper address bits are fully decoded.
- Write (ATIVO, `w`=1):
  - RAM hit: RAM[daddr] <= `dout`.
  - LED hit: `leds` <= `dout`.
  - Unmapped: ignored.
- Read (ATIVO, every cycle): `din` <= RAM[daddr] on a RAM hit, `leds` on a LED hit, 16'h0000 when unmapped.
- Read-before-write: when a read and a write hit the same address in the same cycle, `din` gets the old value.
- Reset asserted at any time, including mid-clear or mid-write: immediate return to reset values, and the full clear sequence restarts.

## Timing
- Clear duration: `busy` falls at rising edge number 2^ADDR_BITS after `reset` deasserts (128 edges at the default).
- Read latency: 1 cycle. `daddr` sampled at edge N gives valid `din` after edge N; `din` holds until the next edge.
- Write: takes effect at the sampling edge. A read of the same address issued at the following edge returns the new value.
- `leds` updates at the write edge. No combinational path exists from any input to any output.

## Configuration
- `MEM_IO_EN` defined:
  - LED register is present and decoded at IO_LED, readable and writable.
- `MEM_IO_EN` undefined:
  - `leds` is tied to 16'h0000.
  - IO_LED is treated as unmapped: writes are ignored and reads return 0.

## Test plan
- Release reset (ADDR_BITS=7) -> `busy`=1 for 128 edges, then 0; read of addr 5 returns 16'h0000.
- In ATIVO, write 16'h1234 to addr 3 (`w`=1 for one cycle), then `daddr`=3, `w`=0 -> `din`=16'h1234 one cycle later.
- RAM[3]=16'h1234; in one cycle `daddr`=3, `w`=1, `dout`=16'hBEEF -> `din`=16'h1234; a repeat read next cycle gives 16'hBEEF.
- With `MEM_IO_EN`, write 16'h00A5 to 16'h1000 -> `leds`=16'h00A5 at that edge; read 16'h1000 -> 16'h00A5. Without the macro -> `leds`=0 and the read returns 0.
- Write 16'hFFFF to unmapped 16'h0080 -> RAM[0] unchanged (still 0); read of 16'h0080 returns 16'h0000.
- After writes, assert `reset` mid-cycle -> `din`=0, `leds`=0, `busy`=1 immediately. `w`=1 during the subsequent clear is ignored, and addr 3 reads 0 after `busy` falls.
